// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared front-end types for the fetch stage and predictor
//
// Purpose: common types used by fetch_pc_unit and fetch_queue.
//   GHR_SIZE_BITS       - global history width shared with the branch predictor
//   fetch_queue_entry_t - one fetched instruction plus its prediction context
//   fetch_state_t       - fetch request FSM states
package rv32i_types;

  localparam int GHR_SIZE_BITS = 10;

  typedef struct packed {
    logic [31:0]              inst;
    logic [31:0]              pc;
    logic                     pred_taken;
    logic [31:0]              pred_target;
    logic [GHR_SIZE_BITS-1:0] ghr;
  } fetch_queue_entry_t;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch queue with flush
//
// Purpose: FIFO of fetch_queue_entry_t between fetch and decode.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   flush      - drop every entry (pointers return to zero)
//   enq        - write enq_data at the tail
//   enq_data   - entry to write
//   deq        - advance the head
//   empty/full - occupancy flags
//   head       - entry at the head (all zero after reset)
module fetch_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq,
  input  fetch_queue_entry_t enq_data,
  input  logic               deq,
  output logic               empty,
  output logic               full,
  output fetch_queue_entry_t head
);

  localparam int IDX_W = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [IDX_W:0]     wptr;
  logic [IDX_W:0]     rptr;
  fetch_queue_entry_t mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[IDX_W] != rptr[IDX_W]) &&
                 (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign head  = mem[rptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq) begin
        mem[wptr[IDX_W-1:0]] <= enq_data;
        wptr                 <= wptr + (IDX_W+1)'(1);
      end
      if (deq) begin
        rptr <= rptr + (IDX_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC register, imem request FSM and fetch queue
//
// Purpose: holds the fetch PC, issues one instruction read at a time and
// queues returned instructions with their prediction for decode.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   pc_at_fetch                    - current fetch PC to the predictor
//   pcout_at_fetch                 - predicted next PC
//   branch_pred_fetch, ghr         - predictor taken flag and global history
//   imem_addr, imem_rmask          - read request (rmask 4'hF for one cycle)
//   imem_rdata, imem_resp          - read response
//   redirect_valid, redirect_pc    - flush/mispredict redirect from the ROB
//   fq_valid, fq_ready             - head handshake towards decode
//   fq_inst, fq_pc, fq_pred_target,
//   fq_pred_taken, fq_ghr          - head entry fields
module fetch_pc_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          FQ_DEPTH = 4,
  parameter int          GHR_BITS = GHR_SIZE_BITS
) (
  input  logic                clk,
  input  logic                rst,
  output logic [31:0]         pc_at_fetch,
  input  logic [31:0]         pcout_at_fetch,
  input  logic                branch_pred_fetch,
  input  logic [GHR_BITS-1:0] ghr,
  output logic [31:0]         imem_addr,
  output logic [3:0]          imem_rmask,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_resp,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                fq_valid,
  input  logic                fq_ready,
  output logic [31:0]         fq_inst,
  output logic [31:0]         fq_pc,
  output logic [31:0]         fq_pred_target,
  output logic                fq_pred_taken,
  output logic [GHR_BITS-1:0] fq_ghr
);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [31:0]        pc;
  logic [31:0]        pc_next;
  logic               issue;
  logic               enq;
  logic               deq;
  logic               q_empty;
  logic               q_full;
  fetch_queue_entry_t enq_entry;
  fetch_queue_entry_t head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // A redirect never cancels a request issued the same cycle; the stale
  // response must still be drained, hence REQ -> DROP. In WAIT/DROP a
  // response arriving with the redirect is simply consumed.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    enq        = 1'b0;
    case (state)
      REQ: begin
        if (!q_full) begin
          issue      = 1'b1;
          state_next = redirect_valid ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_next = imem_resp ? REQ : DROP;
        end else if (imem_resp) begin
          enq        = 1'b1;
          state_next = REQ;
        end
      end
      DROP: begin
        if (imem_resp) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (enq) begin
      pc_next = pcout_at_fetch;
    end
  end

  assign pc_at_fetch = pc;
  assign imem_addr   = pc;
  // State sits at REQ during reset, so the request is also gated by rst.
  assign imem_rmask  = (issue && rst) ? 4'hF : 4'h0;

  assign deq = !q_empty && fq_ready && !redirect_valid;

  always_comb begin
    enq_entry             = '0;
    enq_entry.inst        = imem_rdata;
    enq_entry.pc          = pc;
    enq_entry.pred_taken  = branch_pred_fetch;
    enq_entry.pred_target = pcout_at_fetch;
    enq_entry.ghr         = GHR_SIZE_BITS'(ghr);
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .enq      (enq),
    .enq_data (enq_entry),
    .deq      (deq),
    .empty    (q_empty),
    .full     (q_full),
    .head     (head)
  );

  assign fq_valid       = !q_empty;
  assign fq_inst        = head.inst;
  assign fq_pc          = head.pc;
  assign fq_pred_target = head.pred_target;
  assign fq_pred_taken  = head.pred_taken;
  assign fq_ghr         = GHR_BITS'(head.ghr);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - randomized self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int          DEPTH    = 4;
  localparam int          NCYC     = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_at_fetch;
  logic [31:0] pcout_at_fetch;
  logic        branch_pred_fetch;
  logic [9:0]  ghr;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_inst;
  logic [31:0] fq_pc;
  logic [31:0] fq_pred_target;
  logic        fq_pred_taken;
  logic [9:0]  fq_ghr;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (DEPTH),
    .GHR_BITS (10)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_at_fetch       (pc_at_fetch),
    .pcout_at_fetch    (pcout_at_fetch),
    .branch_pred_fetch (branch_pred_fetch),
    .ghr               (ghr),
    .imem_addr         (imem_addr),
    .imem_rmask        (imem_rmask),
    .imem_rdata        (imem_rdata),
    .imem_resp         (imem_resp),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .fq_valid          (fq_valid),
    .fq_ready          (fq_ready),
    .fq_inst           (fq_inst),
    .fq_pc             (fq_pc),
    .fq_pred_target    (fq_pred_target),
    .fq_pred_taken     (fq_pred_taken),
    .fq_ghr            (fq_ghr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural PC, queue contents, and the single
  // outstanding memory request (whether it is still wanted, and when it returns).
  logic [31:0]        m_pc;
  fetch_queue_entry_t m_q[$];
  bit                 m_pend;
  bit                 m_stale;
  int                 m_lat;
  logic [31:0]        m_data;
  bit                 done_reset;

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_q.delete();
    m_pend  = 1'b0;
    m_stale = 1'b0;
    m_lat   = 0;
    m_data  = '0;
  endtask

  task automatic check_outputs();
    bit exp_issue;
    exp_issue = !m_pend && (m_q.size() < DEPTH);
    check_val("pc_at_fetch", pc_at_fetch, m_pc);
    check_val("imem_rmask", {28'b0, imem_rmask}, exp_issue ? 32'hF : 32'h0);
    if (exp_issue) check_val("imem_addr", imem_addr, m_pc);
    check_val("fq_valid", {31'b0, fq_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      check_val("fq_inst", fq_inst, m_q[0].inst);
      check_val("fq_pc", fq_pc, m_q[0].pc);
      check_val("fq_pred_target", fq_pred_target, m_q[0].pred_target);
      check_val("fq_pred_taken", {31'b0, fq_pred_taken}, {31'b0, m_q[0].pred_taken});
      check_val("fq_ghr", {22'b0, fq_ghr}, {22'b0, m_q[0].ghr});
    end
  endtask

  task automatic drive_and_model(input int cyc);
    bit                 issue;
    bit                 resp;
    bit                 redir;
    bit                 rdy;
    bit                 tk;
    logic [31:0]        npc;
    fetch_queue_entry_t e;

    issue = !m_pend && (m_q.size() < DEPTH);
    resp  = m_pend && (m_lat == 0);
    redir = ($urandom_range(0, 15) == 0);
    // Alternate phases of eager and reluctant decode so the queue fills up.
    if (((cyc / 48) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
    else                       rdy = ($urandom_range(0, 7) == 0);
    tk  = ($urandom_range(0, 3) == 0);
    npc = tk ? ($urandom() & 32'hFFFF_FFFC) : (m_pc + 32'd4);

    imem_resp         = resp;
    imem_rdata        = resp ? m_data : $urandom();
    redirect_valid    = redir;
    redirect_pc       = $urandom() & 32'hFFFF_FFFC;
    fq_ready          = rdy;
    branch_pred_fetch = tk;
    pcout_at_fetch    = npc;
    ghr               = 10'($urandom());

    e.inst        = imem_rdata;
    e.pc          = m_pc;
    e.pred_taken  = tk;
    e.pred_target = npc;
    e.ghr         = ghr;

    if (m_pend && !resp && m_lat > 0) m_lat--;
    if (resp) m_pend = 1'b0;
    if (redir) begin
      m_q.delete();
      m_pc = redirect_pc;
      if (m_pend) m_stale = 1'b1;
    end else begin
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (resp && !m_stale) begin
        m_q.push_back(e);
        m_pc = npc;
      end
    end
    if (issue) begin
      m_pend  = 1'b1;
      m_stale = redir;
      m_lat   = $urandom_range(0, 3);
      m_data  = $urandom();
    end
  endtask

  initial begin
    rst               = 1'b0;
    pcout_at_fetch    = '0;
    branch_pred_fetch = 1'b0;
    ghr               = '0;
    imem_rdata        = '0;
    imem_resp         = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    fq_ready          = 1'b0;
    done_reset        = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check_val("rst_fq_valid", {31'b0, fq_valid}, 32'h0);
    check_val("rst_pc", pc_at_fetch, RESET_PC);
    check_val("rst_rmask", {28'b0, imem_rmask}, 32'h0);
    check_val("rst_fq_inst", fq_inst, 32'h0);
    check_val("rst_fq_pc", fq_pc, 32'h0);
    check_val("rst_fq_target", fq_pred_target, 32'h0);
    check_val("rst_fq_ghr", {22'b0, fq_ghr}, 32'h0);

    rst = 1'b1;
    #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (!done_reset && cyc >= NCYC / 2 && m_pend && m_q.size() >= 2) begin
        done_reset     = 1'b1;
        rst            = 1'b0;
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_val("midrst_fq_valid", {31'b0, fq_valid}, 32'h0);
        check_val("midrst_pc", pc_at_fetch, RESET_PC);
        check_val("midrst_rmask", {28'b0, imem_rmask}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
      end
      check_outputs();
      drive_and_model(cyc);
      @(negedge clk);
      #1;
    end
    check_val("midrst_done", {31'b0, done_reset}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
